// File: rtl/add_sub_checker.sv
// Sweeps all 98 sign-magnitude add/sub vectors through an external unit and
// compares its result and flags against an internally computed reference.
module add_sub_checker #(
  parameter int SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       op,
  output logic [2:0] a,
  output logic [2:0] b,
  input  logic [3:0] r,
  input  logic       sf,
  input  logic       zf,
  input  logic       dzf,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_count,
  output logic [6:0] fail_vec,
  output logic [3:0] fail_r
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [6:0] LAST_VEC = 7'd97;
  localparam logic [6:0] NO_FAIL  = 7'd127;
  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYC - 1);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic [6:0] n_reg;
  logic [2:0] ai_reg, bi_reg;
  logic [2:0] ai_next, bi_next;
  logic       op_next;

  // Operand code list skips 100 (negative zero).
  function automatic logic [2:0] code(input logic [2:0] idx);
    return (idx < 3'd4) ? idx : idx + 3'd1;
  endfunction

  // Reference result derived from the operands currently being driven.
  logic [2:0]        opnd [2];
  logic signed [3:0] sval [2];
  assign opnd[0] = a;
  assign opnd[1] = b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_decode
      logic signed [3:0] mag;
      assign mag      = $signed({2'b00, opnd[gi][1:0]});
      assign sval[gi] = opnd[gi][2] ? -mag : mag;
    end
  endgenerate

  logic signed [3:0] v, v_neg;
  logic [3:0]        exp_r;
  logic              exp_zf;
  logic              mismatch;

  assign v        = op ? (sval[0] - sval[1]) : (sval[0] + sval[1]);
  assign v_neg    = -v;
  assign exp_r    = {v[3], v[3] ? v_neg[2:0] : v[2:0]};
  assign exp_zf   = (v == 4'sd0);
  assign mismatch = (r != exp_r) || (sf != exp_r[3]) || (zf != exp_zf) || dzf;

  always_comb begin
    bi_next = bi_reg + 3'd1;
    ai_next = ai_reg;
    op_next = op;
    if (bi_reg == 3'd6) begin
      bi_next = 3'd0;
      ai_next = ai_reg + 3'd1;
      if (ai_reg == 3'd6) begin
        ai_next = 3'd0;
        op_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      n_reg     <= 7'd0;
      ai_reg    <= 3'd0;
      bi_reg    <= 3'd0;
      op        <= 1'b0;
      a         <= 3'd0;
      b         <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 7'd0;
      fail_vec  <= NO_FAIL;
      fail_r    <= 4'd0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= SETTLE;
            cnt_reg   <= 4'd0;
            n_reg     <= 7'd0;
            ai_reg    <= 3'd0;
            bi_reg    <= 3'd0;
            op        <= 1'b0;
            a         <= code(3'd0);
            b         <= code(3'd0);
            busy      <= 1'b1;
            pass      <= 1'b0;
            err_count <= 7'd0;
            fail_vec  <= NO_FAIL;
            fail_r    <= 4'd0;
          end
        end
        SETTLE: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= CHECK;
            cnt_reg   <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 7'd1;
            if (fail_vec == NO_FAIL) begin
              fail_vec <= n_reg;
              fail_r   <= r;
            end
          end
          if (n_reg == LAST_VEC) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            op        <= 1'b0;
            a         <= 3'd0;
            b         <= 3'd0;
          end else begin
            state_reg <= SETTLE;
            n_reg     <= n_reg + 7'd1;
            ai_reg    <= ai_next;
            bi_reg    <= bi_next;
            op        <= op_next;
            a         <= code(ai_next);
            b         <= code(bi_next);
          end
        end
        DONE: begin
          // err_count is final here, including the last vector's compare.
          pass      <= (err_count == 7'd0);
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_sub_checker.sv
// Table-driven bench: a behavioural add/sub unit with selectable faults feeds
// the checker, and each sweep's final status is compared to hand-computed values.
module tb_add_sub_checker;

  localparam int S = 2;
  localparam int DONE_EDGE = 98 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic       op;
  logic [2:0] a, b;
  logic [3:0] r;
  logic       sf, zf, dzf;
  logic       busy, done, pass;
  logic [6:0] err_count, fail_vec;
  logic [3:0] fail_r;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;

  add_sub_checker #(.SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .r(r), .sf(sf), .zf(zf), .dzf(dzf), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .fail_vec(fail_vec), .fail_r(fail_r)
  );

  always #5 clk = ~clk;

  // Unit model: 0 ideal, 1 stuck-at-zero, 2 dzf stuck, 3 bad r on vector 94,
  // 4 bad r on vectors 48 and 94.
  function automatic logic [6:0] unit_model(input int m, input logic o,
                                            input logic [2:0] x, input logic [2:0] y);
    int va, vb, v;
    logic [3:0] rr;
    va = {30'd0, x[1:0]};
    vb = {30'd0, y[1:0]};
    if (x[2]) va = -va;
    if (y[2]) vb = -vb;
    v  = o ? (va - vb) : (va + vb);
    rr = (v < 0) ? {1'b1, 3'(-v)} : {1'b0, 3'(v)};
    case (m)
      1: return 7'b0000_0_1_0;
      2: return {rr, v < 0, v == 0, 1'b1};
      3: if (o && x == 3'b111 && y == 3'b011) rr = 4'b0000;
      4: begin
        if (!o && x == 3'b111 && y == 3'b111) rr = 4'b0110;
        if (o && x == 3'b111 && y == 3'b011) rr = 4'b0101;
      end
      default: ;
    endcase
    return {rr, v < 0, v == 0, 1'b0};
  endfunction

  logic [6:0] uo;
  always_comb uo = unit_model(mode, op, a, b);
  assign {r, sf, zf, dzf} = uo;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_cleared(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " err_count"}, err_count, 0);
    chk({tag, " fail_vec"}, fail_vec, 127);
    chk({tag, " fail_r"}, fail_r, 0);
    chk({tag, " opab"}, {op, a, b}, 0);
  endtask

  // Start a sweep, follow it to done and check timing and final status.
  task automatic run_sweep(input int m, input int e_err, input int e_fvec,
                           input int e_fr, input int e_pass);
    int cnt;
    mode  = m;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start busy", busy, 1);
    chk("start pass cleared", pass, 0);
    cnt = 0;
    while (cnt < 1000) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 94 * (S + 1))
        chk("vec94 op/a/b", {op, a, b}, {1'b1, 3'b111, 3'b011});
      if (cnt == 48 * (S + 1))
        chk("vec48 op/a/b", {op, a, b}, {1'b0, 3'b111, 3'b111});
      if (done) break;
    end
    chk("done edge", cnt, DONE_EDGE);
    chk("done busy low", busy, 0);
    chk("done opab zero", {op, a, b}, 0);
    @(posedge clk); #1;
    chk("done one cycle", done, 0);
    chk("pass", pass, e_pass);
    chk("err_count", err_count, e_err);
    chk("fail_vec", fail_vec, e_fvec);
    chk("fail_r", fail_r, e_fr);
    @(posedge clk); #1;
    chk("idle hold err", err_count, e_err);
    $display("sweep mode=%0d err=%0d fail_vec=%0d fail_r=%b pass=%0d",
             m, err_count, fail_vec, fail_r, pass);
  endtask

  typedef struct {
    int mode;
    int err;
    int fvec;
    int fr;
    int pass;
  } row_t;

  row_t tbl[5];

  initial begin
    tbl[0] = '{0, 0, 127, 4'b0000, 1};
    tbl[1] = '{1, 84, 1, 4'b0000, 0};
    tbl[2] = '{2, 98, 0, 4'b0000, 0};
    tbl[3] = '{3, 1, 94, 4'b0000, 0};
    tbl[4] = '{4, 2, 48, 4'b0110, 0};

    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_idle_cleared("reset");
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset idle", busy, 0);
    $display("reset checked");

    for (int i = 0; i < 5; i++)
      run_sweep(tbl[i].mode, tbl[i].err, tbl[i].fvec, tbl[i].fr, tbl[i].pass);

    // Faulty sweep interrupted by reset during vector 40, with start pulses while busy.
    mode  = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40 * (S + 1) + 1; c++) begin
      start = (c == 10 || c == 11 || c == 100);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("mid busy", busy, 1);
    chk("mid err nonzero", err_count != 0, 1);
    chk("mid fail_vec", fail_vec, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_idle_cleared("mid reset");
    @(posedge clk); #1;
    chk("after reset idle", busy, 0);
    $display("mid-sweep reset checked");
    run_sweep(0, 0, 127, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_sub_checker.md
ADD_SUB_CHECKER -- requirements
Module: add_sub_checker

Interface
REQ-001 Parameter SETTLE_CYC, default 2, sets the number of cycles each vector is held before its result is sampled (legal range 1..15).
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 start  input  1  sweep request; sampled only in IDLE.
REQ-005 op  output  1  operation to the add/sub unit: 0 = add, 1 = subtract (A-B).
REQ-006 a, b  output  3 each  sign-magnitude operands: bit 2 = sign (1 = negative), bits 1:0 = magnitude.
REQ-007 r  input  4  unit result: bit 3 = sign, bits 2:0 = magnitude.
REQ-008 sf, zf, dzf  input  1 each  unit sign, zero and divide-by-zero flags.
REQ-009 busy  output  1  high from the cycle after start is accepted through the last CHECK cycle.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 pass  output  1  high when the last completed sweep had err_count = 0.
REQ-012 err_count  output  7  number of mismatching vectors in the current or last sweep.
REQ-013 fail_vec  output  7  index of the first mismatching vector; 127 if none.
REQ-014 fail_r  output  4  r captured at the first mismatch; 0000 if none.

Function
REQ-015 Operand code list, in order: 000, 001, 010, 011, 101, 110, 111; code 100 (negative zero) is never driven.
REQ-016 Vector index n = 0..97 maps to op = n/49, a = code[(n mod 49)/7], b = code[n mod 7].
REQ-017 Expected value v = a+b (op=0) or a-b (op=1), range -6..+6.
REQ-018 Expected r = {v<0, |v|}; for v = 0, r = 0000 (never 1000).
REQ-019 Expected sf = r[3]; zf = (v == 0); dzf = 0 for every vector.
REQ-020 A vector mismatches if any of r, sf, zf or dzf differs from its expected value.
REQ-021 States: IDLE, SETTLE, CHECK, DONE.
REQ-022 IDLE: op/a/b = 0, busy = 0; on start = 1 go to SETTLE, load vector 0, clear err_count, set fail_vec = 127 and fail_r = 0000, set pass = 0.
REQ-023 SETTLE: hold the current vector for exactly SETTLE_CYC cycles, then go to CHECK.
REQ-024 CHECK (one cycle): compare the inputs with the expected values. On a mismatch, increment err_count; if fail_vec = 127, capture n into fail_vec and r into fail_r.
REQ-025 CHECK, after the compare: if n = 97 go to DONE; otherwise load vector n+1 on the same edge and go to SETTLE.
REQ-026 DONE (one cycle): done = 1, pass = (err_count == 0), go to IDLE, op/a/b return to 0.
REQ-027 Timing: with start sampled at edge k, vector n is checked at edge k+(n+1)(SETTLE_CYC+1); done is high in cycle k+98(SETTLE_CYC+1)+1.
REQ-028 start while busy is ignored; start held high in IDLE after DONE begins a new sweep.
REQ-029 err_count, fail_vec, fail_r and pass hold their values in IDLE until the next accepted start.
REQ-030 err_count never exceeds 98, so no saturation logic is required.

Reset
REQ-031 rst_n = 0 at any edge, including mid-sweep, forces: IDLE, op/a/b = 0, busy = 0, done = 0, pass = 0, err_count = 0, fail_vec = 127, fail_r = 0000.
REQ-032 Reset takes priority over start and over every state transition.

Verification
REQ-033 Reset: hold rst_n = 0 for 2 cycles -> all outputs at their REQ-031 values; start asserted during reset has no effect.
REQ-034 Ideal behavioural add/sub model, SETTLE_CYC = 2, start at edge 0 -> done in cycle 295, pass = 1, err_count = 0, fail_vec = 127.
REQ-035 Inputs stuck at r = 0000, sf = 0, zf = 1, dzf = 0 -> err_count = 84 (only the 14 zero-result vectors match), fail_vec = 1, fail_r = 0000, pass = 0.
REQ-036 dzf stuck at 1, ideal model otherwise -> err_count = 98, fail_vec = 0.
REQ-037 Ideal model -> vector 94 drives op = 1, a = 111, b = 011 and accepts r = 1110, sf = 1, zf = 0; vector 48 (0+... code 111+111) accepts r = 1110.
REQ-038 rst_n pulsed low during vector 40, and start pulses during busy -> state returns to IDLE with cleared outputs, busy pulses have no effect, and a following start completes with pass = 1.
